sci_alu_pipe: RTL and testbench
===============================

Name: sci_alu_pipe

Overview:
- Parametrised, pipelined successor to the sequential scientific ALU.
- Integer datapath of WIDTH bits with a valid/ready handshake on both sides and a caller-supplied tag carried with each operation.
- Most operations run through a fixed LAT-stage pipeline; signed DIV/REM use an iterative divider.
- Per-result exception/error flags, plus sticky status bits the host clears explicitly.

Parameters:
- WIDTH, 32: operand and result width in bits (>=8).
- LAT, 3: pipeline latency of non-divide ops, in cycles (2..8).
- TAGW, 4: width of the tag carried from input to output.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid && in_ready at rising edge.
- in_a  in  WIDTH  operand a, signed two's complement.
- in_b  in  WIDTH  operand b, signed (shift amount = low $clog2(WIDTH) bits).
- in_op  in  4  opcode.
- in_tag  in  TAGW  caller tag.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_result  out  WIDTH  result.
- out_tag  out  TAGW  tag of this result.
- out_excep  out  1  signed overflow on this result.
- out_err  out  1  divide-by-zero or illegal opcode on this result.
- clr_sticky  in  1  clear sticky flags.
- sticky_excep  out  1  OR of all out_excep delivered since the last clear.
- sticky_err  out  1  OR of all out_err delivered since the last clear.

Behaviour:
- Reset: all outputs 0 except in_ready=1. Pipeline valid bits and divider state are cleared. In-flight ops are discarded with no output. Reset applies mid-divide identically.
- Opcodes: 0 ADD, 1 SUB, 2 MUL (low WIDTH bits), 3 DIV (signed, truncate toward 0), 4 REM (sign follows a), 5 AND, 6 OR, 7 XOR, 8 SHL, 9 SHR (logical), A SRA, B MIN (signed), C MAX (signed), D ABS, E NEG, F reserved.
- Overflow (out_excep=1): ADD/SUB signed overflow; MUL when the full 2*WIDTH product does not sign-fit WIDTH; ABS or NEG of MIN_INT (result MIN_INT); DIV of MIN_INT by -1 (quotient MIN_INT, REM 0).
- Divide by zero: out_err=1. DIV result all-ones; REM result = a. Handled in the pipeline path with latency LAT, no iteration.
- Opcode F: out_err=1, result 0, latency LAT.
- Pipeline ops: an op accepted at edge k has out_valid high after edge k+LAT, absent stalls. Throughput is one op per cycle.
- Back-pressure: when out_valid && !out_ready, the whole pipeline stalls (stage registers hold) and in_ready=0. No bubbles are inserted and no results are lost.
- Divide (op 3/4, b!=0): accepted only if in_ready.
  - in_ready drops the cycle after acceptance and stays low until the divide result is accepted at the output.
  - Divider FSM states: IDLE -> RUN (WIDTH iterations, 1 bit/cycle, restoring on magnitudes) -> FIX (sign correction) -> DONE (holds result).
  - Result appears after edge k+WIDTH+2.
  - Ordering is strictly in order: DONE waits until every earlier pipeline op has left the output, then presents the result. The output mux gives the pipeline priority; the divider holds in DONE.
  - While the divider is in RUN/FIX/DONE, out_ready low stalls only the output; the divider holds in DONE.
- Sticky flags: set on any output handshake carrying the flag. clr_sticky clears them. Simultaneous clr_sticky and a flagged handshake leaves the flag set (set wins).
- out_* fields are stable while out_valid && !out_ready.

Decomposition:
- Package sci_alu_pkg holds:
  - opcode enum (OP_ADD..OP_RSVD);
  - flag struct {excep, err};
  - MIN_INT/ALL_ONES helper functions parametrised by WIDTH.
- Sub-module sci_alu_div: iterative signed divider with start/busy/done, WIDTH parameter, quotient and remainder outputs.

Test Plan:
- WIDTH=32, LAT=3: back-to-back ADD 16+2, SUB 16-2, MUL 16*2 with tags 1,2,3 -> results 18,14,32 on three consecutive cycles starting 3 cycles after the first accept; tags 1,2,3; flags 0.
- ADD 0x7FFFFFFF+1 -> result 0x80000000, out_excep=1, sticky_excep=1. Then pulse clr_sticky -> sticky_excep=0.
- DIV -16/3 then REM -16/3, each issued once in_ready returns:
  - DIV -> -5 at accept+34 cycles;
  - REM -> -1;
  - in_ready low between accept and result handshake.
- DIV 7/0 -> 0xFFFFFFFF and REM 7/0 -> 7, both with out_err=1 and latency 3. Opcode F -> result 0, out_err=1.
- Stream of 6 ADDs with out_ready held low for 5 cycles mid-stream -> in_ready low during the stall, all 6 results delivered in order with correct tags, out fields stable while stalled.
- Reset asserted at iteration 10 of a DIV -> out_valid=0 and in_ready=1 immediately. After release, an ADD 1+1 returns 2 with no stale divide output.

Source files
------------

// File: rtl/sci_alu_pkg.sv
`default_nettype none
// ============================================================================
// Package  : sci_alu_pkg
// Purpose  : Shared types and helpers for the pipelined scientific ALU:
//            opcode encoding, per-result flag bundle and width-generic
//            constant helpers (most-negative value, all-ones pattern).
// Revision : 1.0 - initial release
// ============================================================================
package sci_alu_pkg;

    // Widest datapath the constant helpers can describe; callers slice the
    // low WIDTH bits out of the returned vector.
    localparam int c_MAX_W = 256;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_MUL  = 4'h2,
        OP_DIV  = 4'h3,
        OP_REM  = 4'h4,
        OP_AND  = 4'h5,
        OP_OR   = 4'h6,
        OP_XOR  = 4'h7,
        OP_SHL  = 4'h8,
        OP_SHR  = 4'h9,
        OP_SRA  = 4'hA,
        OP_MIN  = 4'hB,
        OP_MAX  = 4'hC,
        OP_ABS  = 4'hD,
        OP_NEG  = 4'hE,
        OP_RSVD = 4'hF
    } opcode_e;

    typedef struct packed {
        logic excep;   // signed overflow
        logic err;     // divide-by-zero or illegal opcode
    } alu_flags_t;

    // Most negative two's complement value of a w-bit word (only bit w-1 set).
    function automatic logic [c_MAX_W-1:0] min_int(input int w);
        logic [c_MAX_W-1:0] v;
        v = '0;
        v[w-1] = 1'b1;
        return v;
    endfunction

    // All-ones pattern of a w-bit word, zero above bit w-1.
    function automatic logic [c_MAX_W-1:0] all_ones(input int w);
        logic [c_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < w; i++) begin
            v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sci_alu_div.sv
`default_nettype none
// ============================================================================
// Module   : sci_alu_div
// Purpose  : Iterative signed divider. Restoring division on operand
//            magnitudes, one quotient bit per cycle, followed by a single
//            sign-correction cycle. The result is held until acknowledged.
// Ports    : clk, rst_n        - clock, async active-low reset
//            start             - begin a divide (honoured only when idle)
//            dividend, divisor - signed operands, divisor must be non-zero
//            ack               - consumer has taken the result (DONE -> IDLE)
//            busy              - any state other than IDLE
//            done              - result valid on quotient/remainder
//            quotient          - truncated toward zero
//            remainder         - sign follows the dividend
// Revision : 1.0 - initial release
// ============================================================================
module sci_alu_div
    import sci_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             ack,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int                 c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   c_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_quo;     // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0]   r_rem;     // partial remainder
    logic [WIDTH-1:0]   r_dvs;     // divisor magnitude
    logic               r_neg_q;
    logic               r_neg_r;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;

    // Magnitudes are taken as unsigned, so MIN_INT maps to 2^(WIDTH-1)
    // without overflowing.
    assign w_abs_a = dividend[WIDTH-1] ? (~dividend + c_ONE) : dividend;
    assign w_abs_b = divisor[WIDTH-1]  ? (~divisor  + c_ONE) : divisor;

    // One restoring step: bring down the next dividend bit and try to
    // subtract; a borrow in the top bit means "restore".
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_quo   <= w_abs_a;
                        r_rem   <= '0;
                        r_dvs   <= w_abs_b;
                        r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        r_neg_r <= dividend[WIDTH-1];
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!w_diff[WIDTH]) begin
                        r_rem <= w_diff[WIDTH-1:0];
                    end else begin
                        r_rem <= w_shift[WIDTH-1:0];
                    end
                    r_quo <= {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_neg_q) begin
                        r_quo <= ~r_quo + c_ONE;
                    end
                    if (r_neg_r) begin
                        r_rem <= ~r_rem + c_ONE;
                    end
                    r_state <= S_DONE;
                end
                default: begin
                    if (ack) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule
`default_nettype wire

// File: rtl/sci_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : sci_alu_pipe
// Purpose  : Pipelined scientific integer ALU. Non-divide operations are
//            computed on entry and travel through a LAT-deep register
//            pipeline; signed DIV/REM with a non-zero divisor go to an
//            iterative divider. Results leave strictly in issue order.
// Ports    : clk, rst_n                  - clock, async active-low reset
//            in_valid/in_ready           - operation handshake
//            in_a, in_b, in_op, in_tag   - operands, opcode, caller tag
//            out_valid/out_ready         - result handshake
//            out_result, out_tag         - result and its tag
//            out_excep, out_err          - per-result overflow / error
//            clr_sticky                  - clear the sticky flags
//            sticky_excep, sticky_err    - accumulated flags since clear
// Revision : 1.0 - initial release
// ============================================================================
module sci_alu_pipe
    import sci_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LAT   = 3,
    parameter int TAGW  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_op,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAGW-1:0]  out_tag,
    output logic             out_excep,
    output logic             out_err,
    input  logic             clr_sticky,
    output logic             sticky_excep,
    output logic             sticky_err
);

    localparam int                 c_SHW       = $clog2(WIDTH);
    localparam logic [c_MAX_W-1:0] c_MIN_WIDE  = min_int(WIDTH);
    localparam logic [c_MAX_W-1:0] c_ONES_WIDE = all_ones(WIDTH);
    localparam logic [WIDTH-1:0]   c_MIN_INT   = c_MIN_WIDE[WIDTH-1:0];
    localparam logic [WIDTH-1:0]   c_ALL_ONES  = c_ONES_WIDE[WIDTH-1:0];
    localparam logic [WIDTH-1:0]   c_ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Entry-stage compute
    // ------------------------------------------------------------------
    opcode_e            w_op;
    logic [c_SHW-1:0]   w_shamt;
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_dif;
    logic [WIDTH-1:0]   w_neg_a;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_b_zero;
    logic               w_a_min;
    logic               w_lt;
    logic [WIDTH-1:0]   w_res;
    alu_flags_t         w_flg;

    assign w_op     = opcode_e'(in_op);
    assign w_shamt  = in_b[c_SHW-1:0];
    assign w_sum    = in_a + in_b;
    assign w_dif    = in_a - in_b;
    assign w_neg_a  = ~in_a + c_ONE;
    // Sign-extended operands make the low 2*WIDTH bits of the unsigned
    // product equal to the full signed product.
    assign w_prod   = {{WIDTH{in_a[WIDTH-1]}}, in_a} * {{WIDTH{in_b[WIDTH-1]}}, in_b};
    assign w_b_zero = (in_b == '0);
    assign w_a_min  = (in_a == c_MIN_INT);
    assign w_lt     = ($signed(in_a) < $signed(in_b));

    always_comb begin
        w_res = '0;
        w_flg = '0;
        case (w_op)
            OP_ADD: begin
                w_res       = w_sum;
                w_flg.excep = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (w_sum[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res       = w_dif;
                w_flg.excep = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (w_dif[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_MUL: begin
                w_res       = w_prod[WIDTH-1:0];
                // Fits iff the upper half plus the result sign bit are all equal.
                w_flg.excep = !((&w_prod[2*WIDTH-1:WIDTH-1]) || !(|w_prod[2*WIDTH-1:WIDTH-1]));
            end
            // Only the divide-by-zero case of DIV/REM reaches the pipeline.
            OP_DIV: begin
                w_res     = c_ALL_ONES;
                w_flg.err = 1'b1;
            end
            OP_REM: begin
                w_res     = in_a;
                w_flg.err = 1'b1;
            end
            OP_AND:  w_res = in_a & in_b;
            OP_OR:   w_res = in_a | in_b;
            OP_XOR:  w_res = in_a ^ in_b;
            OP_SHL:  w_res = in_a << w_shamt;
            OP_SHR:  w_res = in_a >> w_shamt;
            OP_SRA:  w_res = $signed(in_a) >>> w_shamt;
            OP_MIN:  w_res = w_lt ? in_a : in_b;
            OP_MAX:  w_res = w_lt ? in_b : in_a;
            OP_ABS: begin
                w_res       = in_a[WIDTH-1] ? w_neg_a : in_a;
                w_flg.excep = w_a_min;
            end
            OP_NEG: begin
                w_res       = w_neg_a;
                w_flg.excep = w_a_min;
            end
            default: begin
                w_res     = '0;
                w_flg.err = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake and routing
    // ------------------------------------------------------------------
    logic w_is_div;
    logic w_fire;
    logic w_adv;
    logic w_div_start;
    logic w_pipe_load;
    logic w_div_busy;
    logic w_div_done;
    logic w_div_present;
    logic w_div_ack;
    logic w_pipe_busy;
    logic w_out_hs;
    logic [WIDTH-1:0] w_div_quo;
    logic [WIDTH-1:0] w_div_rem;

    assign w_is_div    = ((w_op == OP_DIV) || (w_op == OP_REM)) && !w_b_zero;
    // A held output freezes every stage, so nothing new may enter either.
    assign w_adv       = !(out_valid && !out_ready);
    // The divider busy window runs from the cycle after its accept until
    // its result is taken, which is exactly when input must be refused.
    assign in_ready    = w_adv && !w_div_busy;
    assign w_fire      = in_valid && in_ready;
    assign w_div_start = w_fire && w_is_div;
    assign w_pipe_load = w_fire && !w_is_div;

    // ------------------------------------------------------------------
    // Result pipeline
    // ------------------------------------------------------------------
    logic             r_vld [LAT];
    logic [WIDTH-1:0] r_res [LAT];
    logic [TAGW-1:0]  r_tag [LAT];
    alu_flags_t       r_flg [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                r_vld[i] <= 1'b0;
                r_res[i] <= '0;
                r_tag[i] <= '0;
                r_flg[i] <= '0;
            end
        end else if (w_adv) begin
            r_vld[0] <= w_pipe_load;
            r_res[0] <= w_res;
            r_tag[0] <= in_tag;
            r_flg[0] <= w_flg;
            for (int i = 1; i < LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_res[i] <= r_res[i-1];
                r_tag[i] <= r_tag[i-1];
                r_flg[i] <= r_flg[i-1];
            end
        end
    end

    always_comb begin
        w_pipe_busy = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            w_pipe_busy = w_pipe_busy | r_vld[i];
        end
    end

    // ------------------------------------------------------------------
    // Divider and its side-band context
    // ------------------------------------------------------------------
    logic            r_div_is_rem;
    logic            r_div_ovf;
    logic [TAGW-1:0] r_div_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_is_rem <= 1'b0;
            r_div_ovf    <= 1'b0;
            r_div_tag    <= '0;
        end else if (w_div_start) begin
            r_div_is_rem <= (w_op == OP_REM);
            // MIN_INT / -1 wraps back to MIN_INT; the matching REM is an
            // exact 0 and raises nothing.
            r_div_ovf    <= (w_op == OP_DIV) && w_a_min && (in_b == c_ALL_ONES);
            r_div_tag    <= in_tag;
        end
    end

    sci_alu_div #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (w_div_start),
        .dividend  (in_a),
        .divisor   (in_b),
        .ack       (w_div_ack),
        .busy      (w_div_busy),
        .done      (w_div_done),
        .quotient  (w_div_quo),
        .remainder (w_div_rem)
    );

    // Every op still in the pipeline was issued before the divide, so the
    // divider result waits until the pipeline is completely empty.
    assign w_div_present = w_div_done && !w_pipe_busy;
    assign w_div_ack     = w_div_present && out_ready;

    // ------------------------------------------------------------------
    // Output mux (pipeline has priority) and sticky flags
    // ------------------------------------------------------------------
    always_comb begin
        out_result = '0;
        out_tag    = '0;
        out_excep  = 1'b0;
        out_err    = 1'b0;
        if (r_vld[LAT-1]) begin
            out_result = r_res[LAT-1];
            out_tag    = r_tag[LAT-1];
            out_excep  = r_flg[LAT-1].excep;
            out_err    = r_flg[LAT-1].err;
        end else if (w_div_present) begin
            out_result = r_div_is_rem ? w_div_rem : w_div_quo;
            out_tag    = r_div_tag;
            out_excep  = r_div_ovf;
        end
    end

    assign out_valid = r_vld[LAT-1] || w_div_present;
    assign w_out_hs  = out_valid && out_ready;

    logic r_sticky_excep;
    logic r_sticky_err;

    // A flagged handshake in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky_excep <= 1'b0;
            r_sticky_err   <= 1'b0;
        end else begin
            r_sticky_excep <= (r_sticky_excep && !clr_sticky) || (w_out_hs && out_excep);
            r_sticky_err   <= (r_sticky_err   && !clr_sticky) || (w_out_hs && out_err);
        end
    end

    assign sticky_excep = r_sticky_excep;
    assign sticky_err   = r_sticky_err;

endmodule
`default_nettype wire

// File: tb/tb_sci_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_sci_alu_pipe
// Purpose  : Self-checking bench for sci_alu_pipe (WIDTH=32, LAT=3, TAGW=4).
//            Stimulus pushes expected results into a queue; an independent
//            monitor pops and compares on every output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sci_alu_pipe;

    localparam int WIDTH = 32;
    localparam int LAT   = 3;
    localparam int TAGW  = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [3:0]       in_op = '0;
    logic [TAGW-1:0]  in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_result;
    logic [TAGW-1:0]  out_tag;
    logic             out_excep;
    logic             out_err;
    logic             clr_sticky = 1'b0;
    logic             sticky_excep;
    logic             sticky_err;

    sci_alu_pipe #(.WIDTH(WIDTH), .LAT(LAT), .TAGW(TAGW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_op        (in_op),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_tag      (out_tag),
        .out_excep    (out_excep),
        .out_err      (out_err),
        .clr_sticky   (clr_sticky),
        .sticky_excep (sticky_excep),
        .sticky_err   (sticky_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  tag;
        logic        ex;
        logic        er;
        int          acc;   // edge index of acceptance
        int          lat;   // required latency, -1 = not checked
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_out    = 0;
    int   cyc      = 0;
    int   hold_cnt = 0;
    bit   rnd_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain 64-bit signed arithmetic on the operands.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] op, input logic [3:0] tag);
        exp_t        e;
        longint      sa, sb, r, mini, maxi;
        logic [63:0] t;
        int          sh;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        maxi = (longint'(1) <<< 31) - 1;
        mini = -(longint'(1) <<< 31);
        sh   = int'(b[4:0]);
        r    = 0;
        e.ex = 1'b0;
        e.er = 1'b0;
        case (op)
            4'h0: begin r = sa + sb; e.ex = (r > maxi) || (r < mini); end
            4'h1: begin r = sa - sb; e.ex = (r > maxi) || (r < mini); end
            4'h2: begin r = sa * sb; e.ex = (r > maxi) || (r < mini); end
            4'h3: begin
                if (b == 0) begin r = -1; e.er = 1'b1; end
                else begin r = sa / sb; e.ex = (r > maxi); end
            end
            4'h4: begin
                if (b == 0) begin r = sa; e.er = 1'b1; end
                else r = sa % sb;
            end
            4'h5: r = longint'(a & b);
            4'h6: r = longint'(a | b);
            4'h7: r = longint'(a ^ b);
            4'h8: r = longint'(a) << sh;
            4'h9: r = longint'(a >> sh);
            4'hA: r = sa >>> sh;
            4'hB: r = (sa < sb) ? sa : sb;
            4'hC: r = (sa > sb) ? sa : sb;
            4'hD: begin r = (sa < 0) ? -sa : sa; e.ex = (r > maxi); end
            4'hE: begin r = -sa; e.ex = (r > maxi); end
            default: begin r = 0; e.er = 1'b1; end
        endcase
        t     = r;
        e.res = t[31:0];
        e.tag = tag;
        e.acc = 0;
        e.lat = -1;
        return e;
    endfunction

    // Driver: offer one op, hold it until accepted, then log the expectation.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input int lat);
        exp_t e;
        int   w;
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        #4;
        w = 0;
        while (!in_ready && w < 300) begin
            @(negedge clk);
            #4;
            w++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: in_ready stayed 0 for op %0h", op);
            in_valid = 1'b0;
            return;
        end
        e     = model(a, b, op, tag);
        e.acc = cyc + 1;
        e.lat = lat;
        sb_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int w;
        w = 0;
        while (sb_q.size() != 0 && w < maxc) begin
            @(negedge clk);
            w++;
        end
        chk("drain_pending", sb_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // While a divide is outstanding, input must stay refused until its result
    // handshake (which bumps n_out).
    task automatic wait_div_result(input int target);
        int w;
        w = 0;
        while (n_out < target && w < 120) begin
            @(negedge clk);
            in_valid = 1'b0;
            #2;
            if (n_out < target) chk("in_ready_during_div", in_ready, 0);
            w++;
        end
        chk("div_result_seen", n_out >= target, 1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(40));
            default: return $urandom();
        endcase
    endfunction

    // Monitor: drives out_ready, checks every handshake against the queue and
    // checks that a held output does not change.
    initial begin : monitor
        exp_t        e;
        logic        stalled;
        logic [31:0] s_res;
        logic [3:0]  s_tag;
        logic        s_ex, s_er;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (hold_cnt > 0) begin
                out_ready = 1'b0;
                hold_cnt--;
            end else if (rnd_ready) begin
                out_ready = ($urandom_range(3) != 0);
            end else begin
                out_ready = 1'b1;
            end
            #4;
            if (stalled && out_valid) begin
                chk("stable_result", out_result, s_res);
                chk("stable_tag", out_tag, s_tag);
                chk("stable_flags", {out_excep, out_err}, {s_ex, s_er});
            end
            if (out_valid && !out_ready) begin
                stalled = 1'b1;
                s_res = out_result;
                s_tag = out_tag;
                s_ex  = out_excep;
                s_er  = out_err;
            end else begin
                stalled = 1'b0;
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: result 0x%0h tag %0h with nothing expected", out_result, out_tag);
                end else begin
                    e = sb_q.pop_front();
                    chk("result", out_result, e.res);
                    chk("tag", out_tag, e.tag);
                    chk("excep", out_excep, e.ex);
                    chk("err", out_err, e.er);
                    if (e.lat >= 0) chk("latency", cyc + 1 - e.acc, e.lat);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] a, b;
        logic [3:0]  op;
        int          base;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_out_flags", {out_excep, out_err}, 0);
        chk("rst_sticky", {sticky_excep, sticky_err}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Back-to-back pipeline ops
        issue(4'h0, 32'd16, 32'd2, 4'd1, LAT);
        issue(4'h1, 32'd16, 32'd2, 4'd2, LAT);
        issue(4'h2, 32'd16, 32'd2, 4'd3, LAT);
        idle();
        drain(50);

        // ADD overflow and sticky clear
        issue(4'h0, 32'h7FFF_FFFF, 32'h1, 4'd4, LAT);
        idle();
        drain(50);
        chk("sticky_excep_set", sticky_excep, 1);
        @(negedge clk) clr_sticky = 1'b1;
        @(negedge clk) clr_sticky = 1'b0;
        #1;
        chk("sticky_excep_clr", sticky_excep, 0);

        // Iterative DIV / REM
        issue(4'h3, -32'sd16, 32'd3, 4'd5, WIDTH + 2);
        wait_div_result(n_out + 1);
        issue(4'h4, -32'sd16, 32'd3, 4'd6, WIDTH + 2);
        wait_div_result(n_out + 1);
        drain(50);

        // Divide by zero and reserved opcode go through the pipeline
        issue(4'h3, 32'd7, 32'd0, 4'd7, LAT);
        issue(4'h4, 32'd7, 32'd0, 4'd8, LAT);
        issue(4'hF, 32'd7, 32'd9, 4'd9, LAT);
        idle();
        drain(50);
        chk("sticky_err_set", sticky_err, 1);
        @(negedge clk) clr_sticky = 1'b1;
        @(negedge clk) clr_sticky = 1'b0;

        // Back-pressure mid-stream
        for (int i = 0; i < 3; i++)
            issue(4'h0, 32'($urandom_range(1000)), 32'($urandom_range(1000)), 4'(i), -1);
        hold_cnt = 5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #2;
            chk("in_ready_stall", in_ready, 0);
        end
        for (int i = 3; i < 6; i++)
            issue(4'h0, 32'($urandom_range(1000)), 32'($urandom_range(1000)), 4'(i), -1);
        idle();
        drain(100);

        // Randomised mix with random back-pressure
        rnd_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(15));
            a  = pick();
            b  = pick();
            if (op == 4'h4 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'hFFFF_FFFE;
            issue(op, a, b, 4'($urandom_range(15)), -1);
            if ($urandom_range(3) == 0) idle();
        end
        idle();
        drain(8000);
        rnd_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset in the middle of a divide
        issue(4'h3, 32'd1000, 32'd7, 4'd11, -1);
        idle();
        repeat (10) @(negedge clk);
        #1;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = n_out;
        issue(4'h0, 32'd1, 32'd1, 4'd10, LAT);
        idle();
        drain(50);
        repeat (50) @(negedge clk);
        chk("outputs_after_reset", n_out - base, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
